// File: rtl/pong_pkg.sv
// Shared pong constants: push-button bit order and count.
// The game top and the input conditioner both index buttons with these.
package pong_pkg;

    localparam int N_BTN = 5;

    localparam int BTN_U = 0;
    localparam int BTN_D = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_C = 4;

    // 10 ms at 100 MHz
    localparam int DEBOUNCE_DEFAULT = 1000000;

    typedef logic [N_BTN-1:0] btn_vec_t;

endpackage

// File: rtl/debounce_bit.sv
// One push-button: two-flop synchroniser, debounce counter, stable level,
// press/release pulses and a press flag held until the next frame tick.
module debounce_bit
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic frame_tick,
    output logic level,
    output logic press,
    output logic unpress,
    output logic press_frame
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             flip;
    logic             rise;

    assign differ = (sync2 != level);
    assign flip   = differ && (cnt == CNT_MAX);
    assign rise   = flip && sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Any bounce back to the stable level restarts the count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (!differ) begin
            cnt <= '0;
        end else if (flip) begin
            cnt   <= '0;
            level <= sync2;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press   <= 1'b0;
            unpress <= 1'b0;
        end else begin
            press   <= rise;
            unpress <= flip && !sync2;
        end
    end

    // A press landing on a frame tick survives into the next frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_frame <= 1'b0;
        end else if (rise) begin
            press_frame <= 1'b1;
        end else if (frame_tick) begin
            press_frame <= 1'b0;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the raw Basys3 push-buttons into clean levels, edge pulses
// and frame-latched press flags for the pong game top.
module btn_conditioner
    import pong_pkg::*;
#(
    parameter int N_BTN           = pong_pkg::N_BTN,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             frame_tick,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_press_frame
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_bit (
            .clk        (clk),
            .reset      (reset),
            .raw        (btn_raw[i]),
            .frame_tick (frame_tick),
            .level      (btn_level[i]),
            .press      (btn_press[i]),
            .unpress    (btn_release[i]),
            .press_frame(btn_press_frame[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with a 4-cycle debounce.
module tb_btn_conditioner;

    localparam int NB = 5;
    localparam int DC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] btn_raw;
    logic          frame_tick;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_press_frame;

    int checks   = 0;
    int failures = 0;
    int npress;
    int nrel;

    btn_conditioner #(
        .N_BTN          (NB),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_raw        (btn_raw),
        .frame_tick     (frame_tick),
        .btn_level      (btn_level),
        .btn_press      (btn_press),
        .btn_release    (btn_release),
        .btn_press_frame(btn_press_frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        btn_raw    = '0;
        frame_tick = 1'b0;
        step(3);
        check("rst_level", 32'(btn_level), 0);
        check("rst_press", 32'(btn_press), 0);
        check("rst_frame", 32'(btn_press_frame), 0);
        @(negedge clk);
        reset = 1'b1;
        step(3);

        // clean press on btn C
        btn_raw = 5'b10000;
        step(5);
        check("clean_early_lvl", 32'(btn_level), 0);
        check("clean_early_prs", 32'(btn_press), 0);
        step(1);
        check("clean_lvl", 32'(btn_level), 32'h10);
        check("clean_prs", 32'(btn_press), 32'h10);
        check("clean_frm", 32'(btn_press_frame), 32'h10);
        step(1);
        check("clean_prs_off", 32'(btn_press), 0);
        check("clean_lvl_hold", 32'(btn_level), 32'h10);
        btn_raw = '0;
        step(6);
        check("clean_rel", 32'(btn_release), 32'h10);
        check("clean_rel_lvl", 32'(btn_level), 0);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        check("clean_frm_clr", 32'(btn_press_frame), 0);
        check("clean_rel_off", 32'(btn_release), 0);
        step(2);

        // bounce on btn U: 3 high, 1 low, then held
        npress  = 0;
        btn_raw = 5'b00001;
        for (int i = 0; i < 3; i++) begin
            step(1);
            npress += int'(btn_press[0]);
        end
        btn_raw = 5'b00000;
        step(1);
        npress += int'(btn_press[0]);
        btn_raw = 5'b00001;
        for (int i = 0; i < 5; i++) begin
            step(1);
            npress += int'(btn_press[0]);
        end
        check("bnc_no_early", 32'(btn_level), 0);
        step(1);
        npress += int'(btn_press[0]);
        check("bnc_lvl", 32'(btn_level), 32'h01);
        check("bnc_prs", 32'(btn_press), 32'h01);
        for (int i = 0; i < 4; i++) begin
            step(1);
            npress += int'(btn_press[0]);
        end
        check("bnc_one_press", 32'(npress), 1);
        btn_raw = '0;
        step(8);
        check("bnc_released", 32'(btn_level), 0);

        // release on btn D
        btn_raw = 5'b00010;
        step(6);
        check("rel_setup", 32'(btn_level), 32'h02);
        step(2);
        npress  = 0;
        nrel    = 0;
        btn_raw = '0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            npress += int'(btn_press[1]);
            nrel   += int'(btn_release[1]);
        end
        check("rel_early", 32'(btn_level), 32'h02);
        step(1);
        npress += int'(btn_press[1]);
        nrel   += int'(btn_release[1]);
        check("rel_pulse", 32'(btn_release), 32'h02);
        check("rel_lvl", 32'(btn_level), 0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            npress += int'(btn_press[1]);
            nrel   += int'(btn_release[1]);
        end
        check("rel_count", 32'(nrel), 1);
        check("rel_no_press", 32'(npress), 0);

        // frame latch on btn L
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        check("frm_cleared", 32'(btn_press_frame), 0);
        btn_raw = 5'b00100;
        step(6);
        check("frm_set", 32'(btn_press_frame), 32'h04);
        step(100);
        check("frm_sticky", 32'(btn_press_frame), 32'h04);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        check("frm_clr", 32'(btn_press_frame), 0);
        btn_raw = '0;
        step(8);
        btn_raw = 5'b00100;
        step(5);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        check("frm_coinc_prs", 32'(btn_press), 32'h04);
        check("frm_coinc", 32'(btn_press_frame), 32'h04);
        step(1);
        check("frm_coinc_hold", 32'(btn_press_frame), 32'h04);
        btn_raw = '0;
        step(8);

        // simultaneous multi-button press
        btn_raw = 5'b10011;
        step(6);
        check("multi_prs", 32'(btn_press), 32'h13);
        check("multi_lvl", 32'(btn_level), 32'h13);
        check("multi_rel", 32'(btn_release), 0);
        btn_raw = '0;
        step(8);
        check("multi_off", 32'(btn_level), 0);

        // async reset mid-count on btn R
        btn_raw = 5'b01000;
        step(4);
        #2;
        reset = 1'b0;
        #1;
        check("arst_lvl", 32'(btn_level), 0);
        check("arst_frm", 32'(btn_press_frame), 0);
        check("arst_prs", 32'(btn_press), 0);
        @(negedge clk);
        reset = 1'b1;
        step(5);
        check("arst_early", 32'(btn_press), 0);
        step(1);
        check("arst_prs_late", 32'(btn_press), 32'h08);
        check("arst_lvl_late", 32'(btn_level), 32'h08);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Input-conditioning stage directly upstream of the pong game top. It turns the five raw Basys3 push-buttons (btnU, btnD, btnL, btnR, btnC) into clean signals for paddle motion, menu selection and launch.
- Per button it synchronises, debounces, and emits a stable level plus single-cycle press/release pulses.
- It also emits a frame-latched press flag. Game logic that samples only on the frame `animate` strobe therefore never misses a press.
- This replaces ad-hoc `pre_launch`-style edge tracking in the game FSM.

Parameters:
- N_BTN, 5, number of buttons conditioned (bit order fixed by package constants).
- DEBOUNCE_CYCLES, 1000000, cycles a synchronised input must differ from the stable level before the level flips (10 ms at 100 MHz). Legal range is 2 or more.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of each per-button counter.

Ports:
- clk  input  1  system clock (100 MHz).
- reset  input  1  asynchronous, active-low reset.
- btn_raw  input  N_BTN  raw asynchronous buttons, active-high.
- frame_tick  input  1  one-cycle frame strobe from the draw stage (`animate`); clears btn_press_frame.
- btn_level  output  N_BTN  debounced button level.
- btn_press  output  N_BTN  one-cycle pulse on each debounced 0->1 transition.
- btn_release  output  N_BTN  one-cycle pulse on each debounced 1->0 transition.
- btn_press_frame  output  N_BTN  sticky press flag, held until the next frame_tick.

Behaviour:
- Reset (reset=0, asynchronous) clears the following to 0:
  - synchroniser flops and counters;
  - btn_level, btn_press, btn_release, btn_press_frame.
- On deassertion, the first active edge operates normally.
- Synchroniser: two flops per bit, sync2 = btn_raw delayed 2 clocks. No logic between the flops.
- Debounce, per bit, every clk edge:
  - If sync2 == btn_level: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: btn_level <= sync2 and counter <= 0.
  - Else: counter <= counter+1.
- Latency: raw stepping before edge 0 and held gives sync2 updated after edge 2, and btn_level flips after edge 2+DEBOUNCE_CYCLES. A bounce that returns sync2 to btn_level at any point restarts the count from 0.
- btn_press / btn_release are registered and asserted in the same cycle btn_level changes. Each is exactly one cycle wide. They are never both high for the same bit.
- btn_press_frame, per bit, with priority:
  1. btn_press => 1. A press coinciding with frame_tick is kept for the next frame.
  2. Else frame_tick => 0.
  3. Else hold.
- Bits are fully independent. Simultaneous transitions on several bits are all reported in the same cycle.
- The counter never wraps: its maximum value is DEBOUNCE_CYCLES-1.
- Reset mid-count discards the pending transition. After reset btn_level=0, so a button held through reset reports a press DEBOUNCE_CYCLES+2 cycles after release of reset.
- No combinational path from any input to any output.

Decomposition:
- pong_pkg holds the bit indices BTN_U=0, BTN_D=1, BTN_L=2, BTN_R=3, BTN_C=4, and N_BTN=5. The game top and this block both index with these.
- Natural sub-module: debounce_bit (synchroniser, counter, level, press/release, frame flag for one button). btn_conditioner is a generate loop of N_BTN instances.

Test Plan (DEBOUNCE_CYCLES=4 in simulation):
- Clean press: reset released; btn_raw[4] 0->1 before edge 0, held -> btn_level[4]=1 and btn_press[4]=1 after edge 6; btn_press[4]=0 after edge 7; other bits stay 0.
- Bounce: btn_raw[0] high 3 cycles, low 1, then high held -> no press during the bounce; btn_level[0] rises exactly 6 edges after the final rise; one btn_press pulse total.
- Release: from btn_level[1]=1, drop raw and hold -> btn_release[1] is a single pulse 6 edges later, btn_level[1]=0, btn_press[1] never pulses.
- Frame latch: press bit 2, no frame_tick for 100 cycles -> btn_press_frame[2] stays 1; frame_tick pulse -> 0 next cycle. Then press coinciding with frame_tick -> btn_press_frame[2]=1 after that edge.
- Multi-button: raw = 5'b10011 simultaneously -> btn_press = 5'b10011 in one cycle, btn_level = 5'b10011.
- Async reset mid-count: raw[3] high, assert reset at count 2 without a clock edge -> all outputs 0 immediately. Release reset with raw still high -> press after 6 edges.
